// File: rtl/ram_copier.sv
// ram_copier: block-copy initiator for the 32K x 16 data RAM.
// Copies len_i consecutive words from src_i to dst_i in strictly ascending
// order, one word every two cycles (READ then WRITE). All outputs are
// registered; each one is computed from the next state and next datapath
// values, so it is valid in the cycle that state is occupied.
module ram_copier #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [ADDR_W:0]   len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              ram_load_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  // Largest copy is the whole RAM; larger requests are clamped to it.
  localparam logic [ADDR_W:0]   MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   REM_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   src_r, src_s;
  logic [ADDR_W-1:0]   dst_r, dst_s;
  logic [ADDR_W:0]     rem_r, rem_s;
  logic [ADDR_W:0]     len_clamped_s;
  logic [DATA_W-1:0]   hold_r, hold_s;

  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                load_r, load_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [DATA_W-1:0]   wdata_r, wdata_s;

  // Clamp the requested length to the RAM size.
  always_comb begin
    if (len_i > MAX_LEN) begin
      len_clamped_s = MAX_LEN;
    end else begin
      len_clamped_s = len_i;
    end
  end

  // Next-state and datapath update for the copy sequencer.
  always_comb begin
    state_s = state_r;
    src_s   = src_r;
    dst_s   = dst_r;
    rem_s   = rem_r;
    hold_s  = hold_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          src_s = src_i;
          dst_s = dst_i;
          rem_s = len_clamped_s;
          if (len_clamped_s != REM_ZERO) begin
            state_s = ST_READ;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        // Read data is combinational from the address driven this cycle.
        hold_s  = ram_data_i;
        src_s   = src_r + ADDR_ONE;
        state_s = ST_WRITE;
      end
      ST_WRITE: begin
        dst_s = dst_r + ADDR_ONE;
        rem_s = rem_r - REM_ONE;
        if (rem_r == REM_ONE) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the state about to be entered, so they can be registered.
  always_comb begin
    busy_s  = 1'b0;
    done_s  = 1'b0;
    load_s  = 1'b0;
    addr_s  = ADDR_ZERO;
    wdata_s = DATA_ZERO;
    case (state_s)
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      ST_READ: begin
        busy_s = 1'b1;
        addr_s = src_s;
      end
      ST_WRITE: begin
        busy_s  = 1'b1;
        load_s  = 1'b1;
        addr_s  = dst_s;
        wdata_s = hold_s;
      end
      ST_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any copy in progress.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= ST_IDLE;
      src_r   <= ADDR_ZERO;
      dst_r   <= ADDR_ZERO;
      rem_r   <= REM_ZERO;
      hold_r  <= DATA_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      load_r  <= 1'b0;
      addr_r  <= ADDR_ZERO;
      wdata_r <= DATA_ZERO;
    end else begin
      state_r <= state_s;
      src_r   <= src_s;
      dst_r   <= dst_s;
      rem_r   <= rem_s;
      hold_r  <= hold_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      load_r  <= load_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
    end
  end

  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign ram_load_o = load_r;
  assign ram_addr_o = addr_r;
  assign ram_data_o = wdata_r;

endmodule

// File: tb/tb_ram_copier.sv
// Directed testbench for ram_copier with a behavioural 32K x 16 RAM.
module tb_ram_copier;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [14:0] src_i;
  logic [14:0] dst_i;
  logic [15:0] len_i;
  logic        busy_o;
  logic        done_o;
  logic        ram_load_o;
  logic [14:0] ram_addr_o;
  logic [15:0] ram_data_o;
  logic [15:0] ram_data_i;

  logic [15:0] mem [0:32767];

  int n_checks = 0;
  int n_errors = 0;

  int done_cyc;
  int busy_cnt;
  int load_cnt;
  logic [33:0] abort_snap;

  ram_copier #(.ADDR_W(15), .DATA_W(16)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .src_i      (src_i),
    .dst_i      (dst_i),
    .len_i      (len_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .ram_load_o (ram_load_o),
    .ram_addr_o (ram_addr_o),
    .ram_data_o (ram_data_o),
    .ram_data_i (ram_data_i)
  );

  always #5 clk_i = ~clk_i;

  // RAM model: combinational read, write on rising edge, held by reset.
  assign ram_data_i = reset_i ? 16'h0000 : mem[ram_addr_o];

  always @(posedge clk_i) begin
    if (!reset_i && ram_load_o) mem[ram_addr_o] <= ram_data_o;
  end

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start a copy at edge 0, then watch cycles 1..budget sampled on falling edges.
  // inj: cycle in which a conflicting start is raised; rst: cycle in which reset is raised.
  task automatic run_copy(input logic [14:0] s, input logic [14:0] d, input logic [15:0] l,
                          input int inj, input int rst, input int budget);
    done_cyc   = 0;
    busy_cnt   = 0;
    load_cnt   = 0;
    abort_snap = '0;
    @(negedge clk_i);
    src_i = s; dst_i = d; len_i = l; start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk_i);
      if (done_o && done_cyc == 0) done_cyc = c;
      if (busy_o) busy_cnt++;
      if (ram_load_o) load_cnt++;
      if (rst > 0 && c == rst + 1)
        abort_snap = {busy_o, done_o, ram_load_o, ram_addr_o, ram_data_o};
      if (c == inj) begin
        src_i = 15'h0100; dst_i = 15'h0500; len_i = 16'd2; start_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      reset_i = (c == rst) ? 1'b1 : 1'b0;
      if (done_cyc != 0 && c > done_cyc) break;
    end
    start_i = 1'b0;
    reset_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    reset_i = 1'b1; start_i = 1'b0; src_i = 15'h0; dst_i = 15'h0; len_i = 16'h0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_busy", {33'd0, busy_o}, 34'd0);
    check("rst_done", {33'd0, done_o}, 34'd0);
    check("rst_load", {33'd0, ram_load_o}, 34'd0);
    check("rst_addr", {19'd0, ram_addr_o}, 34'd0);
    check("rst_data", {18'd0, ram_data_o}, 34'd0);
    reset_i = 1'b0;

    // Basic copy of four words.
    mem[16'h0100] = 16'h1111; mem[16'h0101] = 16'h2222;
    mem[16'h0102] = 16'h3333; mem[16'h0103] = 16'h4444;
    run_copy(15'h0100, 15'h0200, 16'd4, 0, 0, 40);
    check("basic_done_cyc", done_cyc, 34'd9);
    check("basic_busy_cnt", busy_cnt, 34'd8);
    check("basic_load_cnt", load_cnt, 34'd4);
    check("basic_dst0", {18'd0, mem[16'h0200]}, 34'h1111);
    check("basic_dst1", {18'd0, mem[16'h0201]}, 34'h2222);
    check("basic_dst2", {18'd0, mem[16'h0202]}, 34'h3333);
    check("basic_dst3", {18'd0, mem[16'h0203]}, 34'h4444);
    check("basic_dst4", {18'd0, mem[16'h0204]}, 34'h0000);
    check("basic_src0", {18'd0, mem[16'h0100]}, 34'h1111);
    check("basic_src3", {18'd0, mem[16'h0103]}, 34'h4444);
    check("basic_idle_busy", {33'd0, busy_o}, 34'd0);

    // Zero length.
    run_copy(15'h0100, 15'h0300, 16'd0, 0, 0, 20);
    check("zero_done_cyc", done_cyc, 34'd1);
    check("zero_load_cnt", load_cnt, 34'd0);
    check("zero_busy_cnt", busy_cnt, 34'd0);

    // Address wrap-around with ascending overlap.
    mem[16'h7FFE] = 16'hAAAA; mem[16'h7FFF] = 16'hBBBB;
    mem[16'h0000] = 16'hCCCC; mem[16'h0001] = 16'hDDDD;
    run_copy(15'h7FFE, 15'h7FFF, 16'd3, 0, 0, 30);
    check("wrap_done_cyc", done_cyc, 34'd7);
    check("wrap_7fff", {18'd0, mem[16'h7FFF]}, 34'hAAAA);
    check("wrap_0000", {18'd0, mem[16'h0000]}, 34'hAAAA);
    check("wrap_0001", {18'd0, mem[16'h0001]}, 34'hAAAA);
    check("wrap_7ffe", {18'd0, mem[16'h7FFE]}, 34'hAAAA);

    // Overlap dst = src + 1 propagates the first word.
    for (int i = 0; i < 5; i++) mem[16'h0010 + i] = 16'(i + 1);
    run_copy(15'h0010, 15'h0011, 16'd4, 0, 0, 30);
    check("ovl_done_cyc", done_cyc, 34'd9);
    for (int i = 0; i < 5; i++) check($sformatf("ovl_w%0d", i), {18'd0, mem[16'h0010 + i]}, 34'd1);

    // Identity copy leaves memory unchanged.
    for (int i = 0; i < 8; i++) mem[16'h0020 + i] = 16'hB000 + 16'(i);
    run_copy(15'h0020, 15'h0020, 16'd8, 0, 0, 40);
    check("ident_done_cyc", done_cyc, 34'd17);
    check("ident_busy_cnt", busy_cnt, 34'd16);
    for (int i = 0; i < 8; i++)
      check($sformatf("ident_w%0d", i), {18'd0, mem[16'h0020 + i]}, 34'hB000 + 34'(i));

    // Start while busy is ignored.
    for (int i = 0; i < 4; i++) mem[16'h0300 + i] = 16'h5A01 + 16'(i);
    run_copy(15'h0300, 15'h0400, 16'd4, 3, 0, 40);
    check("ign_done_cyc", done_cyc, 34'd9);
    check("ign_load_cnt", load_cnt, 34'd4);
    check("ign_dst0", {18'd0, mem[16'h0400]}, 34'h5A01);
    check("ign_dst3", {18'd0, mem[16'h0403]}, 34'h5A04);
    check("ign_other", {18'd0, mem[16'h0500]}, 34'h0000);
    @(negedge clk_i);
    check("ign_no_restart", {33'd0, busy_o}, 34'd0);

    // Reset in cycle 4 aborts the copy after word 0.
    for (int i = 0; i < 4; i++) mem[16'h0600 + i] = 16'h7001 + 16'(i);
    run_copy(15'h0600, 15'h0700, 16'd4, 0, 4, 14);
    check("abort_done_seen", done_cyc, 34'd0);
    check("abort_outputs", abort_snap, 34'd0);
    check("abort_w0", {18'd0, mem[16'h0700]}, 34'h7001);
    check("abort_w1", {18'd0, mem[16'h0701]}, 34'h0000);
    check("abort_w2", {18'd0, mem[16'h0702]}, 34'h0000);

    // Length clamp to the full RAM.
    run_copy(15'h0000, 15'h0000, 16'hFFFF, 0, 0, 70000);
    check("clamp_done_cyc", done_cyc, 34'd65537);
    check("clamp_load_cnt", load_cnt, 34'd32768);
    check("clamp_busy_cnt", busy_cnt, 34'd65536);
    check("clamp_keep", {18'd0, mem[16'h0100]}, 34'h1111);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_copier.md
# ram_copier

Block-copy initiator for the 32K x 16 data RAM. It drives the RAM's load/address/write-data inputs and samples the RAM's combinational read data, copying `len_i` consecutive words from a source address to a destination address. It sits between a control source (CPU-side register or test harness) and the RAM port, which it owns while busy.

## Interface
Parameters:
- `ADDR_W`, 15: RAM address width (32768 words).
- `DATA_W`, 16: RAM word width.

Ports:
- `clk_i`  in  1: clock. Single clock domain; all state changes on the rising edge.
- `reset_i`  in  1: synchronous, active-high reset.
- `start_i`  in  1: request a copy. Sampled only in IDLE.
- `src_i`  in  15: first source word address. Latched with `start_i`.
- `dst_i`  in  15: first destination word address. Latched with `start_i`.
- `len_i`  in  16: word count, 0..32768. Latched with `start_i`. Values above 32768 are clamped to 32768.
- `busy_o`  out  1: high in READ and WRITE.
- `done_o`  out  1: one-cycle pulse when a copy completes.
- `ram_load_o`  out  1: RAM write enable.
- `ram_addr_o`  out  15: RAM address.
- `ram_data_o`  out  16: RAM write data.
- `ram_data_i`  in  16: RAM read data. This is combinational from `ram_addr_o` and valid in the same cycle.

## Operation
- The state machine has four states: IDLE, READ, WRITE, DONE.
- **IDLE**:
  - Outputs are all zero.
  - If `start_i` = 1, latch `src`, `dst` and `rem = min(len_i, 32768)`.
  - If `rem` != 0, go to READ; otherwise go to DONE.
- **READ**:
  - Drive `ram_addr_o = src` and `ram_load_o = 0`.
  - Register `ram_data_i` into the holding register `hold`.
  - Advance `src = src + 1` modulo 2^15.
  - Go to WRITE.
- **WRITE**:
  - Drive `ram_addr_o = dst`, `ram_data_o = hold` and `ram_load_o = 1`.
  - Advance `dst = dst + 1` modulo 2^15 and `rem = rem - 1`.
  - If the pre-decrement `rem` = 1, go to DONE; otherwise go to READ.
- **DONE**:
  - `done_o = 1`, RAM outputs zero.
  - Go to IDLE unconditionally.
- `start_i` outside IDLE is ignored. It is not queued.
- Address arithmetic is 15-bit wrap-around: source or destination 0x7FFF is followed by 0x0000.
- Overlap rule: words are copied in strictly ascending order, and each READ observes all earlier WRITEs.
  - With `dst` = `src` + 1, the first word propagates across the whole range. This is the defined behaviour; no memmove semantics.
  - With `dst` = `src`, the copy completes with memory unchanged.
- `ram_data_o` equals `hold` only in WRITE and is 0 in every other state.
- Reset mid-operation:
  - The copy aborts in the same edge and the FSM goes to IDLE.
  - `ram_load_o` drops, so no further write occurs. Words already written remain.
  - No `done_o` pulse is produced.

## Timing
- Reset values (after a reset edge): state IDLE; `busy_o`, `done_o` and `ram_load_o` are 0; `ram_addr_o` and `ram_data_o` are 0; `hold`, `src`, `dst` and `rem` are 0.
- With `start_i` accepted at edge 0 and N >= 1:
  - READ for word k (k = 0..N-1) occupies cycle 2k+1.
  - WRITE for word k occupies cycle 2k+2, and RAM commits at the end of that cycle.
  - `done_o` is high in cycle 2N+1.
  - IDLE is reached in cycle 2N+2, and a new `start_i` can be accepted there.
- N = 0: `done_o` is high in cycle 1, there are no RAM writes, and `busy_o` never rises.
- `busy_o` is high for exactly 2N cycles.
- Throughput is 1 word per 2 cycles.
- The RAM shares `reset_i`. While reset is high the RAM read data is 0, which is irrelevant because the copier is in IDLE.

## Test plan
- Basic copy: RAM[0x0100..0x0103] = 0x1111, 0x2222, 0x3333, 0x4444; start with src=0x0100, dst=0x0200, len=4 -> RAM[0x0200..0x0203] matches, `done_o` pulses in cycle 9, `busy_o` high for exactly 8 cycles, source region unchanged.
- Zero length: start with len=0 -> `done_o` in cycle 1, `ram_load_o` never asserted, `busy_o` stays 0.
- Wrap-around: src=0x7FFE, dst=0x7FFF, len=3, with RAM[0x7FFE]=0xAAAA, RAM[0x7FFF]=0xBBBB, RAM[0x0000]=0xCCCC -> writes land at 0x7FFF and then 0x0000, then 0x0001, with ascending-overlap values 0xAAAA, 0xAAAA, 0xAAAA (RAM[0x0000] is written before it is read).
- Overlap and identity:
  - src=0x10, dst=0x11, len=4 with RAM[0x10..0x14] = 1, 2, 3, 4, 5 -> RAM[0x11..0x14] = 1, 1, 1, 1.
  - src=dst=0x20, len=8 -> memory unchanged, `done_o` in cycle 17.
- Start while busy and reset abort:
  - Assert `start_i` with different operands during a len=4 copy -> ignored, original copy completes unchanged.
  - Second run: assert `reset_i` in cycle 4 of a len=4 copy -> only word 0 has been written, state IDLE next cycle, all outputs 0, no `done_o` pulse.
- Length clamp: len=0xFFFF -> exactly 32768 writes, `done_o` in cycle 65537.
